sys_pll_seq: RTL and testbench
==============================

# sys_pll_seq

Reset and lock sequencer for the system PLL (20 MHz reference in, 100/125 MHz out). It runs on the free-running reference clock and drives the PLL reset with a timed pulse. It then qualifies `locked` for a stability window and only then releases the system reset to the PLL-clocked logic. It retries on lock timeout, reports failure, and handles loss of lock at run time.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 200: refclk cycles `pll_rst` is held high per attempt (10 µs at 20 MHz); ≥1.
- `LOCK_TIMEOUT_CYCLES`, 20000: refclk cycles allowed for synchronized lock to rise after `pll_rst` falls; ≥1.
- `LOCK_STABLE_CYCLES`, 1000: consecutive cycles synchronized lock must stay high before release; ≥1.
- `MAX_RETRIES`, 3: timed-out attempts tolerated before FAIL; ≥1.
- `CNT_W`, 8: width of `retry_cnt` and `lock_loss_cnt`.

Ports:
- `refclk`, in, 1: reference clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`; asynchronous to `refclk`.
- `restart`, in, 1: single-cycle request to restart sequencing from any state.
- `pll_rst`, out, 1: reset to the PLL `rst` input.
- `sys_rst`, out, 1: active-high reset for the PLL-clocked domains. Consumers resynchronize it per domain.
- `ready`, out, 1: high only in RUN.
- `fail`, out, 1: high only in FAIL.
- `retry_cnt`, out, CNT_W: timeouts in the current sequence; saturating.
- `lock_loss_cnt`, out, CNT_W: lock losses seen in RUN since `rst`; saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL. A single down-counter `tmr` is loaded on every state entry.
- PLL_RST: `pll_rst`=1, `sys_rst`=1. After `RST_PULSE_CYCLES` cycles → WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=1 → STABLE.
  - On timer expiry, `retry_cnt`+1. If the new value is ≥ `MAX_RETRIES` → FAIL, otherwise → PLL_RST.
- STABLE: `sys_rst`=1.
  - `lock_s`=0 → WAIT_LOCK with the timer reloaded. This is not counted as a retry.
  - After `LOCK_STABLE_CYCLES` consecutive high cycles → RUN.
- RUN: `sys_rst`=0, `ready`=1. `lock_s`=0 → `lock_loss_cnt`+1, then the configured loss action (see Configuration).
- FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Leaves only on `restart` or `rst`.
- `restart` in any state → PLL_RST and clears `retry_cnt`. `lock_loss_cnt` is kept.
- Precedence: `rst` > `restart` > lock-loss > timer expiry.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- `rst` values: state PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, both counters 0, `tmr`=`RST_PULSE_CYCLES`−1.
- `rst` mid-operation, e.g. in RUN: all outputs take their reset values on the next edge, so `sys_rst` reasserts in 1 cycle.
- All outputs are registered. Output change is 1 cycle after the state change.
- `pll_rst` high width is exactly `RST_PULSE_CYCLES`.
- Synchronizer latency is 2 cycles. `pll_locked` rising to `sys_rst` falling takes 2 + `LOCK_STABLE_CYCLES` + 1 cycles when the lock arrives mid-WAIT_LOCK.
- `pll_locked` falling in RUN: `sys_rst` rises and `ready` falls exactly 3 cycles later.
- A lock rising on the same cycle the timeout expires counts as lock: go to STABLE, no retry counted.
- `restart` held for several cycles reloads the PLL_RST timer each cycle. The pulse length is counted from the last assertion.

## Configuration
- `SYS_PLL_SEQ_AUTO_RELOCK_EN` defined: lock loss in RUN → PLL_RST. `retry_cnt` clears and the full sequence reruns automatically.
- Not defined: lock loss in RUN → FAIL. Only `restart` or `rst` recovers.
- `lock_loss_cnt` increments in both builds.

## Structure
- Package `sys_pll_seq_pkg`:
  - state enum `sys_pll_seq_state_t`.
  - default-parameter constants.
  - a `TMR_W` helper function: `$clog2` of the maximum of the three cycle parameters, +1.
- Sub-module `sys_pll_lock_sync`: 2-flop synchronizer, reset to 0, marked with ASYNC_REG attributes.
- Everything else lives in one FSM module.

## Test plan
Bench parameters: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Nominal bring-up: release `rst`, raise `pll_locked` 10 cycles later → `pll_rst` high exactly 4 cycles; `sys_rst` falls 11 cycles after the lock rise; `ready`=1.
- Lock glitch in STABLE: drop `pll_locked` for 3 cycles at stable cycle 5 → return to WAIT_LOCK, `retry_cnt`=0, full 8-cycle window rerun before release.
- Lock never arrives: → two `pll_rst` pulses, `retry_cnt`=2, `fail`=1; `restart` pulse → `fail`=0, `retry_cnt`=0, new 4-cycle pulse.
- Loss in RUN, relock build: drop `pll_locked` → `sys_rst`=1 after 3 cycles, `lock_loss_cnt`=1, new `pll_rst` pulse. Non-relock build: `fail`=1 instead.
- `rst` during RUN → next edge `sys_rst`=1, `pll_rst`=1, `ready`=0, `lock_loss_cnt`=0.
- Saturation: force 256 lock losses with `CNT_W`=8 → `lock_loss_cnt` holds at 255.

Source files
------------

// File: rtl/sys_pll_seq_pkg.sv
// sys_pll_seq_pkg: shared types, default parameters and the timer-width helper
// for the system PLL reset/lock sequencer.
package sys_pll_seq_pkg;

    // Sequencer states. The FSM carries these as plain 3-bit codes.
    typedef enum logic [2:0] {
        SEQ_PLL_RST   = 3'd0,
        SEQ_WAIT_LOCK = 3'd1,
        SEQ_STABLE    = 3'd2,
        SEQ_RUN       = 3'd3,
        SEQ_FAIL      = 3'd4
    } sys_pll_seq_state_t;

    // Defaults sized for a 20 MHz reference clock.
    localparam int DEF_RST_PULSE_CYCLES    = 200;    // 10 us PLL reset pulse
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 20000;  // 1 ms to acquire lock
    localparam int DEF_LOCK_STABLE_CYCLES  = 1000;   // 50 us of steady lock
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 8;

    // Width of the shared down-counter: enough bits for the largest load
    // value, plus one bit of headroom.
    function automatic int tmr_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sys_pll_seq_lock_sync.sv
// sys_pll_lock_sync: two-flop synchronizer that brings the PLL locked flag,
// which is asynchronous to refclk, into the refclk domain. Both stages clear
// on reset so a lock seen before reset cannot leak into the new sequence.
module sys_pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    // Metastability filter: first stage may go metastable, second is clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sys_pll_seq.sv
// sys_pll_seq: reset and lock sequencer for the system PLL.
// Runs on the free-running reference clock, pulses the PLL reset, waits for
// lock, qualifies it over a stability window and only then releases the
// system reset. Lock timeouts are retried up to MAX_RETRIES times.
// Build option: define SYS_PLL_SEQ_AUTO_RELOCK_EN to rerun the whole
// sequence automatically when lock is lost in RUN; without it a lock loss
// parks the sequencer in FAIL until restart or rst.
module sys_pll_seq
    import sys_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       dbg_state
);

    // State codes, kept numerically identical to the package enum.
    localparam logic [2:0] ST_PLL_RST   = SEQ_PLL_RST;
    localparam logic [2:0] ST_WAIT_LOCK = SEQ_WAIT_LOCK;
    localparam logic [2:0] ST_STABLE    = SEQ_STABLE;
    localparam logic [2:0] ST_RUN       = SEQ_RUN;
    localparam logic [2:0] ST_FAIL      = SEQ_FAIL;

    localparam int TW = tmr_w(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                              LOCK_STABLE_CYCLES);

    // The timer counts down to zero, so each load is "cycles - 1" and a
    // state lasts exactly the configured number of cycles.
    localparam logic [TW-1:0] TMR_RST_LOAD    = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_TIMEOUT_LOAD = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_STABLE_LOAD = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE         = TW'(1);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      RETRY_LIMIT = 32'(MAX_RETRIES);

    logic             lock_s;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;

    logic [CNT_W-1:0] retry_inc;
    logic [CNT_W-1:0] loss_inc;
    logic             retry_exhausted;
    logic             tmr_zero;

    logic             pll_rst_q;
    logic             sys_rst_q;
    logic             ready_q;
    logic             fail_q;

    // All sequencing decisions use the synchronized lock only.
    sys_pll_lock_sync u_lock_sync (
        .clk_i   (refclk),
        .rst_i   (rst),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    // Saturating increments and the retry-limit test feed the FSM below.
    always_comb begin
        retry_inc       = (retry_q == CNT_MAX) ? retry_q : retry_q + CNT_ONE;
        loss_inc        = (loss_q == CNT_MAX) ? loss_q : loss_q + CNT_ONE;
        retry_exhausted = (32'(retry_inc) >= RETRY_LIMIT);
        tmr_zero        = (tmr_q == '0);
    end

    // Next-state logic. Precedence: restart, then lock loss, then timer
    // expiry (rst is handled in the register block and beats everything).
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart) begin
            // Held restart keeps reloading, so the pulse counts from the
            // last cycle restart was seen.
            state_d = ST_PLL_RST;
            tmr_d   = TMR_RST_LOAD;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (tmr_zero) begin
                        state_d = ST_WAIT_LOCK;
                        tmr_d   = TMR_TIMEOUT_LOAD;
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock wins over a simultaneous timeout.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        tmr_d   = TMR_STABLE_LOAD;
                    end else if (tmr_zero) begin
                        retry_d = retry_inc;
                        if (retry_exhausted) begin
                            state_d = ST_FAIL;
                            tmr_d   = '0;
                        end else begin
                            state_d = ST_PLL_RST;
                            tmr_d   = TMR_RST_LOAD;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end

                ST_STABLE: begin
                    // A dropout restarts the lock wait; it is not a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        tmr_d   = TMR_TIMEOUT_LOAD;
                    end else if (tmr_zero) begin
                        state_d = ST_RUN;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q - TMR_ONE;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        loss_d = loss_inc;
`ifdef SYS_PLL_SEQ_AUTO_RELOCK_EN
                        state_d = ST_PLL_RST;
                        tmr_d   = TMR_RST_LOAD;
                        retry_d = '0;
`else
                        state_d = ST_FAIL;
                        tmr_d   = '0;
`endif
                    end
                end

                ST_FAIL: begin
                    // Parked; only restart or rst leave this state.
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d = ST_PLL_RST;
                    tmr_d   = TMR_RST_LOAD;
                end
            endcase
        end
    end

    // State, timer, counters and the registered outputs. Outputs decode the
    // next state so they switch on the same edge the state does.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            tmr_q     <= TMR_RST_LOAD;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sys_pll_seq.sv
// tb_sys_pll_seq: self-checking bench for sys_pll_seq with small timing
// parameters. A cycle model written in terms of phases and elapsed cycles
// predicts every output each cycle; table vectors and hand sequences check
// the latencies and corner cases directly.
module tb_sys_pll_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_ST  = 8;
    localparam int P_MAX = 2;
    localparam int CW    = 8;
    localparam int W     = 4 + 2 * CW;
    localparam int SAT   = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          refclk     = 1'b0;
    logic          rst        = 1'b1;
    logic          pll_locked = 1'b0;
    logic          restart    = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic          fail;
    logic [CW-1:0] retry_cnt;
    logic [CW-1:0] lock_loss_cnt;
    logic [2:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 refclk = ~refclk;

    sys_pll_seq #(
        .RST_PULSE_CYCLES    (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_ST),
        .MAX_RETRIES         (P_MAX),
        .CNT_W               (CW)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} phase_t;

    phase_t     ph      = M_RST;
    int         elapsed = 0;
    int         m_retry = 0;
    int         m_loss  = 0;
    logic       h_old   = 1'b0;  // lock as the sequencer sees it now
    logic       h_new   = 1'b0;  // lock one cycle behind that
    logic [W-1:0] exp_q[$];

    task automatic model_step();
        logic lk;
        if (rst) begin
            ph = M_RST; elapsed = 0; m_retry = 0; m_loss = 0;
            h_old = 1'b0; h_new = 1'b0;
        end else begin
            lk = h_old;
            h_old = h_new;
            h_new = pll_locked;
            if (restart) begin
                ph = M_RST; elapsed = 0; m_retry = 0;
            end else begin
                case (ph)
                    M_RST: begin
                        elapsed++;
                        if (elapsed == P_RST) begin ph = M_WAIT; elapsed = 0; end
                    end
                    M_WAIT: begin
                        if (lk) begin
                            ph = M_STABLE; elapsed = 0;
                        end else begin
                            elapsed++;
                            if (elapsed == P_TO) begin
                                if (m_retry < SAT) m_retry++;
                                ph = (m_retry >= P_MAX) ? M_FAIL : M_RST;
                                elapsed = 0;
                            end
                        end
                    end
                    M_STABLE: begin
                        if (!lk) begin
                            ph = M_WAIT; elapsed = 0;
                        end else begin
                            elapsed++;
                            if (elapsed == P_ST) begin ph = M_RUN; elapsed = 0; end
                        end
                    end
                    M_RUN: begin
                        if (!lk) begin
                            if (m_loss < SAT) m_loss++;
`ifdef SYS_PLL_SEQ_AUTO_RELOCK_EN
                            ph = M_RST; elapsed = 0; m_retry = 0;
`else
                            ph = M_FAIL;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp_q.push_back({(ph == M_RST) || (ph == M_FAIL), ph != M_RUN,
                         ph == M_RUN, ph == M_FAIL,
                         CW'(m_retry), CW'(m_loss)});
    endtask

    initial begin
        forever begin
            @(posedge refclk);
            model_step();
        end
    end

    // ---------------- scoreboard: every cycle vs model ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge refclk);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_model t=%0t got {pll_rst,sys_rst,ready,fail,retry,loss}=%h expected %h",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the first sample after the last rst edge (sample 0).
    task automatic do_reset();
        tick();
        rst = 1'b1; restart = 1'b0; pll_locked = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic wait_ready(input logic want, input int budget, input string name);
        int n;
        n = 0;
        while (ready !== want && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (ready !== want) begin
            n_bad++;
            $display("FAIL %s: ready=%0b after %0d cycles, expected %0b", name, ready, n, want);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int lock_at;    // sample at which pll_locked rises (-1: never)
        int g_at;       // sample at which a dropout starts
        int g_len;      // dropout length in cycles (0: none)
        int exp_ready;  // first sample with ready=1 (-1: never)
        int exp_retry;
        int exp_fail;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vector(input int idx, input vec_t v);
        int first_ready;
        int width;
        bit in_pulse;
        do_reset();
        first_ready = -1;
        width = 0;
        in_pulse = 1'b1;
        for (int s = 0; s < 80; s++) begin
            if (in_pulse && pll_rst) width++;
            else in_pulse = 1'b0;
            if (ready && first_ready < 0) first_ready = s;
            if (s == v.lock_at) pll_locked = 1'b1;
            if (v.g_len > 0 && s == v.g_at) pll_locked = 1'b0;
            if (v.g_len > 0 && s == v.g_at + v.g_len) pll_locked = 1'b1;
            tick();
        end
        check($sformatf("vec%0d_pll_rst_width", idx), width, P_RST);
        check($sformatf("vec%0d_ready_at", idx), first_ready, v.exp_ready);
        check($sformatf("vec%0d_retry_cnt", idx), int'(retry_cnt), v.exp_retry);
        check($sformatf("vec%0d_fail", idx), int'(fail), v.exp_fail);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int run_len;
        logic lvl;

        vecs[0] = '{10, -1, 0, 21, 0, 0};  // nominal: release 11 after lock
        vecs[1] = '{ 0, -1, 0, 13, 0, 0};  // lock already up during pll_rst
        vecs[2] = '{ 1, -1, 0, 13, 0, 0};
        vecs[3] = '{ 3, -1, 0, 14, 0, 0};
        vecs[4] = '{21, -1, 0, 32, 0, 0};  // lock on the timeout cycle wins
        vecs[5] = '{22, -1, 0, 37, 1, 0};  // one cycle late: one retry
        vecs[6] = '{40, -1, 0, 51, 1, 0};  // lock during second attempt
        vecs[7] = '{10, 15, 3, 29, 0, 0};  // dropout at stable cycle 5
        vecs[8] = '{-1, -1, 0, -1, 2, 1};  // never locks: FAIL

        // reset state
        tick();
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_ready", int'(ready), 0);
        check("reset_fail", int'(fail), 0);
        check("reset_retry", int'(retry_cnt), 0);
        check("reset_loss", int'(lock_loss_cnt), 0);

        for (int i = 0; i < 9; i++) run_vector(i, vecs[i]);

        // restart out of FAIL (vector 8 leaves the sequencer there)
        pulse_restart();
        check("restart_fail_clr", int'(fail), 0);
        check("restart_retry_clr", int'(retry_cnt), 0);
        w = 0;
        while (pll_rst && w < 20) begin w++; tick(); end
        check("restart_pulse_width", w, P_RST);

        // restart held 3 cycles: pulse counts from the last one
        restart = 1'b1; tick(); tick(); tick();
        restart = 1'b0;
        w = 0;
        while (pll_rst && w < 20) begin w++; tick(); end
        check("restart_held_width", w, P_RST);

        // loss of lock in RUN
        do_reset();
        pll_locked = 1'b1;
        wait_ready(1'b1, 40, "loss_bringup");
        pll_locked = 1'b0;
        tick(); check("loss_sys_rst_c1", int'(sys_rst), 0);
        tick(); check("loss_sys_rst_c2", int'(sys_rst), 0);
        tick(); check("loss_sys_rst_c3", int'(sys_rst), 1);
        check("loss_ready", int'(ready), 0);
        check("loss_cnt", int'(lock_loss_cnt), 1);
        check("loss_pll_rst", int'(pll_rst), 1);
`ifdef SYS_PLL_SEQ_AUTO_RELOCK_EN
        check("loss_fail", int'(fail), 0);
`else
        check("loss_fail", int'(fail), 1);
`endif

        // rst while in RUN
        pll_locked = 1'b1;
        pulse_restart();
        wait_ready(1'b1, 40, "rst_bringup");
        rst = 1'b1;
        tick();
        check("rst_run_sys_rst", int'(sys_rst), 1);
        check("rst_run_pll_rst", int'(pll_rst), 1);
        check("rst_run_ready", int'(ready), 0);
        check("rst_run_loss", int'(lock_loss_cnt), 0);
        rst = 1'b0;

        // lock-loss counter saturation
        do_reset();
        pll_locked = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pulse_restart();
            wait_ready(1'b1, 40, "sat_ready");
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, "sat_loss");
            pll_locked = 1'b1;
            if (i == 254) check("sat_reach_255", int'(lock_loss_cnt), SAT);
        end
        check("sat_hold_255", int'(lock_loss_cnt), SAT);

        // randomized lock behaviour, restarts and resets vs the model
        do_reset();
        run_len = 0;
        lvl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (run_len == 0) begin
                lvl = ~lvl;
                pll_locked = lvl;
                if (lvl) run_len = int'($urandom_range(1, 40));
                else if ($urandom_range(0, 7) == 0) run_len = int'($urandom_range(30, 70));
                else run_len = int'($urandom_range(1, 25));
            end
            run_len--;
            restart = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 699) == 0);
            tick();
        end
        restart = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
